mvb_frame_stim: RTL

Parametrised single-clock MVB traffic generator that drives the Encode block's FIFO-write and frame-send interface. Replaces derived 6/3 MHz clocks with clock-enable strobes in the 24 MHz domain. Adds programmable word count, selectable data pattern, and master/slave frame selection. Adds frame-completion tracking with timeout and overrun reporting. Sits between board-level switches/bring-up logic and the encoder input.

---
 rtl/mvb_frame_stim.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mvb_frame_stim.sv
// MVB frame traffic generator: periodic start ticks, strobed FIFO writes of a
// selectable pattern, send request, and completion/timeout/overrun tracking.
module mvb_frame_stim #(
    parameter int unsigned         DATA_W    = 16,
    parameter int unsigned         MAX_WORDS = 32,
    parameter int unsigned         CNT_W     = $clog2(MAX_WORDS + 1),
    parameter int unsigned         PERIOD    = 25000,
    parameter int unsigned         STRB_DIV  = 8,
    parameter int unsigned         SEND_CYC  = 30,
    parameter int unsigned         TIMEOUT   = 4096,
    parameter logic [DATA_W-1:0]   SEED      = DATA_W'(16'h7EC3),
    parameter logic [DATA_W-1:0]   POLY      = DATA_W'(16'hB400)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              master_sel,
    input  logic              frame_over,
    output logic [DATA_W-1:0] fifo_data,
    output logic              fifo_write_en,
    output logic [6:0]        frame_length,
    output logic              M_frame,
    output logic              S_frame,
    output logic              send_frame,
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        overrun_cnt,
    output logic              timeout_err
);

    localparam int unsigned TMAX_A = (SEND_CYC > STRB_DIV) ? SEND_CYC : STRB_DIV;
    localparam int unsigned TMAX   = (TIMEOUT > TMAX_A) ? TIMEOUT : TMAX_A;
    localparam int unsigned TW     = $clog2(TMAX + 1);
    localparam int unsigned PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StSend, StWaitDone} state_t;

    state_t            state_q;
    logic [PW-1:0]     pcnt_q;
    logic [TW-1:0]     tmr_q;
    logic [CNT_W-1:0]  left_q;
    logic [DATA_W-1:0] pat_q;
    logic [1:0]        mode_q;
    logic              we_q;
    logic              send_q;
    logic              tick;
    logic [CNT_W-1:0]  wc_clamped;
    logic [DATA_W-1:0] pat_init;

    function automatic logic [DATA_W-1:0] advance(input logic [1:0] m,
                                                  input logic [DATA_W-1:0] p);
        case (m)
            2'd0:    return p + DATA_W'(1);
            2'd1:    return p;
            2'd2:    return (p >> 1) ^ (p[0] ? POLY : '0);
            default: return {p[DATA_W-2:0], p[DATA_W-1]};
        endcase
    endfunction

    assign tick       = enable && (pcnt_q == PW'(PERIOD - 1));
    assign wc_clamped = (word_count > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : word_count;

    // Walking-one always starts at 1; an all-zero LFSR seed would lock up.
    always_comb begin
        pat_init = SEED;
        if (mode == 2'd3) begin
            pat_init = DATA_W'(1);
        end else if (mode == 2'd2 && SEED == '0) begin
            pat_init = DATA_W'(1);
        end
    end

    assign fifo_write_en = we_q & enable;
    assign send_frame    = send_q & enable;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            pcnt_q       <= '0;
            tmr_q        <= '0;
            left_q       <= '0;
            pat_q        <= SEED;
            mode_q       <= 2'd0;
            we_q         <= 1'b0;
            send_q       <= 1'b0;
            fifo_data    <= SEED;
            frame_length <= '0;
            M_frame      <= 1'b0;
            S_frame      <= 1'b1;
            busy         <= 1'b0;
            frame_cnt    <= '0;
            overrun_cnt  <= '0;
            timeout_err  <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            pcnt_q <= (!enable || tick) ? '0 : pcnt_q + PW'(1);
            if (tick && state_q != StIdle && overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
            if (!enable) begin
                state_q <= StIdle;
                busy    <= 1'b0;
                send_q  <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (tick && word_count != '0) begin
                            state_q      <= StLoad;
                            busy         <= 1'b1;
                            left_q       <= wc_clamped;
                            frame_length <= 7'(wc_clamped);
                            mode_q       <= mode;
                            M_frame      <= master_sel;
                            S_frame      <= ~master_sel;
                            pat_q        <= pat_init;
                            tmr_q        <= '0;
                        end
                    end
                    StLoad: begin
                        if (tmr_q == TW'(STRB_DIV - 1)) begin
                            tmr_q <= '0;
                            if (left_q == '0) begin
                                state_q <= StSend;
                                send_q  <= 1'b1;
                            end
                        end else begin
                            tmr_q <= tmr_q + TW'(1);
                        end
                        // Register the write one cycle early so the strobe lands on STRB_DIV-1.
                        if (tmr_q == TW'(STRB_DIV - 2) && left_q != '0) begin
                            we_q      <= 1'b1;
                            fifo_data <= pat_q;
                            pat_q     <= advance(mode_q, pat_q);
                            left_q    <= left_q - CNT_W'(1);
                        end
                    end
                    StSend: begin
                        if (tmr_q == TW'(SEND_CYC - 1)) begin
                            state_q <= StWaitDone;
                            send_q  <= 1'b0;
                            tmr_q   <= '0;
                        end else begin
                            tmr_q <= tmr_q + TW'(1);
                        end
                    end
                    default: begin
                        if (frame_over) begin
                            frame_cnt <= frame_cnt + 16'd1;
                            state_q   <= StIdle;
                            busy      <= 1'b0;
                        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                            timeout_err <= 1'b1;
                            state_q     <= StIdle;
                            busy        <= 1'b0;
                        end else begin
                            tmr_q <= tmr_q + TW'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule
